// File: rtl/multiword_add_sequencer.sv
// Multi-word adder that reuses one WIDTH-bit ripple-carry adder across WORDS
// chunks, one chunk per clock, with valid/ready handshakes on both sides.
// Optional feature macro: MULTIWORD_SUBTRACT_EN adds an op input (1 = A-B).

// Plain WIDTH-bit ripple-carry adder built from full-adder cells.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_c,
    output logic             cout_c
);

    logic [WIDTH:0] carry_chain;

    assign carry_chain[0] = cin;

    // One full-adder cell per bit; carry ripples LSB to MSB.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
        assign sum_c[i]           = a[i] ^ b[i] ^ carry_chain[i];
        assign carry_chain[i + 1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
    end

    assign cout_c = carry_chain[WIDTH];

endmodule

module multiword_add_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
`ifdef MULTIWORD_SUBTRACT_EN
    input  logic                   op,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int unsigned TOTAL_W = WIDTH * WORDS;
    localparam int unsigned IDX_W   = $clog2(WORDS);
    localparam int unsigned LAST    = WORDS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TOTAL_W-1:0] a_reg;
    logic [TOTAL_W-1:0] b_reg;
    logic [TOTAL_W-1:0] acc;
    logic [TOTAL_W-1:0] acc_next_c;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               op_reg;
    logic               op_in_c;
    logic               last_c;
    logic [WIDTH-1:0]   a_chunk_c;
    logic [WIDTH-1:0]   b_chunk_c;
    logic [WIDTH-1:0]   add_sum_c;
    logic               add_cout_c;

`ifdef MULTIWORD_SUBTRACT_EN
    assign op_in_c = op;
`else
    assign op_in_c = 1'b0;
`endif

    assign last_c    = (idx == IDX_W'(LAST));
    assign a_chunk_c = a_reg[int'(idx) * WIDTH +: WIDTH];
    // Subtraction is A + ~B + 1; the +1 comes from the initial carry.
    assign b_chunk_c = b_reg[int'(idx) * WIDTH +: WIDTH] ^ {WIDTH{op_reg}};

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a      (a_chunk_c),
        .b      (b_chunk_c),
        .cin    (carry),
        .sum_c  (add_sum_c),
        .cout_c (add_cout_c)
    );

    // Accumulator with the current chunk slot replaced by the adder result.
    always_comb begin
        acc_next_c = acc;
        acc_next_c[int'(idx) * WIDTH +: WIDTH] = add_sum_c;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_c)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake/status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next == RUN);
        end
    end

    // Operand capture, chunk-serial accumulation and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 1'b0;
            acc    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op_in_c;
                        carry  <= op_in_c | cin;
                        acc    <= '0;
                        idx    <= '0;
                        sum    <= '0;
                        cout   <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_next_c;
                    carry <= add_cout_c;
                    if (last_c) begin
                        sum  <= acc_next_c;
                        cout <= add_cout_c;
                        idx  <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer at WIDTH=4, WORDS=4.
// Build with MULTIWORD_SUBTRACT_EN defined to also cover subtraction.
`timescale 1ns/1ps
module tb_multiword_add_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned TW    = WIDTH * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic          op;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] sum;
    logic          cout;
    logic          busy;

    int n_checks;
    int n_errors;

    logic [TW:0] exp_q[$];

    multiword_add_sequencer #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MULTIWORD_SUBTRACT_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result {cout, sum} for one request.
    function automatic logic [TW:0] model(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                          input logic c, input logic o);
        logic [TW:0] yy;
        logic [TW:0] cc;
        yy = {1'b0, (o ? ~y : y)};
        cc = (o || c) ? (TW+1)'(1) : (TW+1)'(0);
        return {1'b0, x} + yy + cc;
    endfunction

    // Drive one request in IDLE, push its expectation, then scramble the inputs.
    task automatic send(input logic [TW-1:0] x, input logic [TW-1:0] y,
                        input logic c, input logic o);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = x;
        b        = y;
        cin      = c;
        op       = o;
        in_valid = 1'b1;
        exp_q.push_back(model(x, y, c, o));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = ~c;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait (bounded) for out_valid; outputs must read zero until then.
    task automatic wait_done(input bit check_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                chk("sum_zero_in_run", 32'(sum), 32'd0);
                chk("cout_zero_in_run", 32'(cout), 32'd0);
            end
        end
        if (!seen) chk("out_valid_timeout", 32'd0, 32'd1);
        else if (check_lat) chk("latency", 32'(lat), 32'd4);
    endtask

    // Compare the result at the head of the scoreboard and complete the handshake.
    task automatic take();
        logic [TW:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(sum), 32'(e[TW-1:0]));
            chk("cout", 32'(cout), 32'(e[TW]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [TW:0] e;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed adds, including a full-length carry ripple.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0); wait_done(1'b1); take();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_done(1'b1); take();
        send(16'h1234, 16'h0000, 1'b1, 1'b0); wait_done(1'b1); take();

        // Result held under back-pressure while a new request waits.
        send(16'hABCD, 16'h1111, 1'b0, 1'b0);
        wait_done(1'b1);
        e        = exp_q[0];
        a        = 16'h4321;
        b        = 16'h0F0F;
        cin      = 1'b1;
        op       = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_sum", 32'(sum), 32'(e[TW-1:0]));
            chk("stall_cout", 32'(cout), 32'(e[TW]));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        exp_q.push_back(model(16'h4321, 16'h0F0F, 1'b1, 1'b0));
        take();
        chk("no_accept_on_handshake", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept_after_handshake", 32'(busy), 32'd1);
        chk("in_ready_low_in_run", 32'(in_ready), 32'd0);
        wait_done(1'b1);
        take();

        // Reset in the middle of RUN aborts the operation.
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0004, 1'b0, 1'b0); wait_done(1'b1); take();

`ifdef MULTIWORD_SUBTRACT_EN
        send(16'h0005, 16'h0007, 1'b1, 1'b1); wait_done(1'b1); take();
        send(16'h0007, 16'h0005, 1'b0, 1'b1); wait_done(1'b1); take();
`endif

        // A few random requests.
        for (int i = 0; i < 6; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom),
`ifdef MULTIWORD_SUBTRACT_EN
                 1'($urandom)
`else
                 1'b0
`endif
            );
            wait_done(1'b0);
            take();
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
